// File: rtl/mp_csa_accum.sv
// Carry-save accumulator with a segmented carry-propagate resolve for the Montgomery datapath.
// Define MP_CSA_COND_SUB_EN to add the final conditional subtraction of the modulus.
module mp_csa_accum #(
  parameter int WIDTH = 514,
  parameter int SEG   = 103
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_m,
  output logic             lsb,
  output logic [WIDTH-1:0] res,
  output logic             res_valid,
  output logic             res_reduced
);

  localparam int NSEG = (WIDTH + SEG - 1) / SEG;
  localparam int SW   = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam logic [SW-1:0]    LAST_SEG = SW'(NSEG - 1);
  localparam logic [WIDTH-1:0] SEG_ONES = WIDTH'({SEG{1'b1}});

  localparam logic [1:0] OP_CLEAR   = 2'b00;
  localparam logic [1:0] OP_ACC     = 2'b01;
  localparam logic [1:0] OP_SHIFT   = 2'b10;
  localparam logic [1:0] OP_RESOLVE = 2'b11;

  // FIN is the commit step after the last segment, before the one-cycle DONE pulse.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PROP,
    ST_SUB,
    ST_FIN,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    seg_q, seg_d;
  logic             cy_q, cy_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             res_valid_q, res_valid_d;
  logic             reduced_q, reduced_d;

  int unsigned      seg_base;
  logic [WIDTH-1:0] seg_mask;
  logic [SEG-1:0]   s_seg, c_seg;
  logic [SEG:0]     add_seg;
  logic [WIDTH-1:0] xsum, maj;

`ifdef MP_CSA_COND_SUB_EN
  logic             bw_q, bw_d;
  logic [SEG-1:0]   m_seg;
  logic [SEG:0]     sub_seg;
`else
  logic             unused_m;
  assign unused_m = ^in_m;
`endif

  always_comb begin
    state_d     = state_q;
    seg_d       = seg_q;
    cy_d        = cy_q;
    s_d         = s_q;
    c_d         = c_q;
    cmd_ready_d = cmd_ready_q;
    res_valid_d = 1'b0;
    reduced_d   = reduced_q;

    seg_base = int'(seg_q) * SEG;
    seg_mask = SEG_ONES << seg_base;
    s_seg    = SEG'(s_q >> seg_base);
    c_seg    = SEG'(c_q >> seg_base);
    add_seg  = {1'b0, s_seg} + {1'b0, c_seg} + (SEG + 1)'(cy_q);
    xsum     = s_q ^ c_q ^ in_a;
    maj      = (s_q & c_q) | (s_q & in_a) | (c_q & in_a);
`ifdef MP_CSA_COND_SUB_EN
    bw_d    = bw_q;
    m_seg   = SEG'(in_m >> seg_base);
    sub_seg = {1'b0, s_seg} - {1'b0, m_seg} - (SEG + 1)'(bw_q);
`endif

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          reduced_d = 1'b0;
          case (cmd_op)
            OP_CLEAR: begin
              s_d = '0;
              c_d = '0;
            end
            OP_ACC: begin
              s_d = xsum;
              c_d = {maj[WIDTH-2:0], 1'b0};
            end
            OP_SHIFT: begin
              s_d = xsum >> 1;
              c_d = {1'b0, maj[WIDTH-2:0]};
            end
            OP_RESOLVE: begin
              state_d     = ST_PROP;
              seg_d       = '0;
              cy_d        = 1'b0;
              cmd_ready_d = 1'b0;
            end
            default: ;
          endcase
        end
      end
      // Ripple one segment per cycle; the carry out of the top segment falls off.
      ST_PROP: begin
        s_d  = (s_q & ~seg_mask) | (WIDTH'(add_seg[SEG-1:0]) << seg_base);
        c_d  = c_q & ~seg_mask;
        cy_d = add_seg[SEG];
        if (seg_q == LAST_SEG) begin
          seg_d = '0;
`ifdef MP_CSA_COND_SUB_EN
          state_d = ST_SUB;
          bw_d    = 1'b0;
`else
          state_d = ST_FIN;
`endif
        end else begin
          seg_d = seg_q + 1'b1;
        end
      end
`ifdef MP_CSA_COND_SUB_EN
      ST_SUB: begin
        c_d  = (c_q & ~seg_mask) | (WIDTH'(sub_seg[SEG-1:0]) << seg_base);
        bw_d = sub_seg[SEG];
        if (seg_q == LAST_SEG) begin
          seg_d   = '0;
          state_d = ST_FIN;
        end else begin
          seg_d = seg_q + 1'b1;
        end
      end
`endif
      ST_FIN: begin
`ifdef MP_CSA_COND_SUB_EN
        if (!bw_q) begin
          s_d       = c_q;
          reduced_d = 1'b1;
        end
`endif
        c_d         = '0;
        state_d     = ST_DONE;
        res_valid_d = 1'b1;
      end
      ST_DONE: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b1;
      end
      default: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      seg_q       <= '0;
      cy_q        <= 1'b0;
      s_q         <= '0;
      c_q         <= '0;
      cmd_ready_q <= 1'b1;
      res_valid_q <= 1'b0;
      reduced_q   <= 1'b0;
`ifdef MP_CSA_COND_SUB_EN
      bw_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      seg_q       <= seg_d;
      cy_q        <= cy_d;
      s_q         <= s_d;
      c_q         <= c_d;
      cmd_ready_q <= cmd_ready_d;
      res_valid_q <= res_valid_d;
      reduced_q   <= reduced_d;
`ifdef MP_CSA_COND_SUB_EN
      bw_q        <= bw_d;
`endif
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign lsb         = s_q[0] ^ c_q[0];
  assign res         = s_q;
  assign res_valid   = res_valid_q;
  assign res_reduced = reduced_q;

endmodule

// File: tb/tb_mp_csa_accum.sv
// Testbench for mp_csa_accum: directed scenarios plus randomized command streams
// compared against an integer model of the accumulated value.
module tb_mp_csa_accum;

  localparam int WIDTH = 514;
  localparam int SEG   = 103;
  localparam int NSEG  = (WIDTH + SEG - 1) / SEG;
`ifdef MP_CSA_COND_SUB_EN
  localparam int EXP_LAT = 2 * NSEG + 1;
`else
  localparam int EXP_LAT = NSEG + 1;
`endif

  localparam logic [1:0] OP_CLEAR   = 2'b00;
  localparam logic [1:0] OP_ACC     = 2'b01;
  localparam logic [1:0] OP_SHIFT   = 2'b10;
  localparam logic [1:0] OP_RESOLVE = 2'b11;

  logic             clk = 1'b0;
  logic             resetn;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_m;
  logic             lsb;
  logic [WIDTH-1:0] res;
  logic             res_valid;
  logic             res_reduced;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] model_v;
  logic [WIDTH-1:0] all_ones;

  always #5 clk = ~clk;

  mp_csa_accum #(.WIDTH(WIDTH), .SEG(SEG)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .in_a        (in_a),
    .in_m        (in_m),
    .lsb         (lsb),
    .res         (res),
    .res_valid   (res_valid),
    .res_reduced (res_reduced)
  );

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [WIDTH-1:0] rand_wide(input int bits);
    logic [WIDTH-1:0] v = '0;
    for (int i = 0; i < (WIDTH + 31) / 32; i++) v = (v << 32) | WIDTH'($urandom);
    return v >> (WIDTH - bits);
  endfunction

  // Reference resolve: binary value, optionally minus the modulus when V >= M.
  task automatic model_resolve(input logic [WIDTH-1:0] m, output logic [WIDTH-1:0] r,
                               output logic red);
    red = 1'b0;
`ifdef MP_CSA_COND_SUB_EN
    red = (model_v >= m);
`endif
    r = red ? model_v - m : model_v;
    model_v = r;
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("[TB] FAIL ready_timeout: cmd_ready=%0b expected 1", cmd_ready);
    end
  endtask

  task automatic do_op(input logic [1:0] op, input logic [WIDTH-1:0] a);
    logic [WIDTH:0] t;
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op    = op;
    in_a      = a;
    @(posedge clk);
    #1;
    t = {1'b0, model_v} + {1'b0, a};
    case (op)
      OP_CLEAR: model_v = '0;
      OP_ACC:   model_v = t[WIDTH-1:0];
      OP_SHIFT: model_v = t[WIDTH:1];
      default: ;
    endcase
  endtask

  task automatic do_resolve(input logic [WIDTH-1:0] m, output int lat,
                            output logic [WIDTH-1:0] r, output logic red,
                            output logic busy_ok, output logic pulse_ok);
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op    = OP_RESOLVE;
    in_m      = m;
    in_a      = rand_wide(64);
    @(posedge clk);
    lat = 0; r = '0; red = 1'b0; busy_ok = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      @(posedge clk);
      #1;
      if (cmd_ready) busy_ok = 1'b0;
      if (res_valid) begin
        lat = n; r = res; red = res_reduced;
      end
    end
    @(posedge clk);
    #1;
    pulse_ok = !res_valid && cmd_ready;
  endtask

  task automatic test_reset();
    resetn = 1'b0; cmd_valid = 1'b0; cmd_op = OP_CLEAR; in_a = '0; in_m = '0;
    model_v = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %0b expected 1", cmd_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", res_valid); end
    checks++; if (res !== '0) begin errors++; $display("[TB] FAIL reset_res: got %0h expected 0", res); end
    checks++; if (res_reduced !== 1'b0) begin errors++; $display("[TB] FAIL reset_reduced: got %0b expected 0", res_reduced); end
    checks++; if (lsb !== 1'b0) begin errors++; $display("[TB] FAIL reset_lsb: got %0b expected 0", lsb); end
  endtask

  task automatic test_basic();
    int lat; logic [WIDTH-1:0] r, er; logic red, ered, busy_ok, pulse_ok;
    do_op(OP_ACC, WIDTH'(5));
    do_op(OP_ACC, WIDTH'(7));
    checks++; if (lsb !== 1'b0) begin errors++; $display("[TB] FAIL basic_lsb: got %0b expected 0", lsb); end
    do_resolve(WIDTH'(100), lat, r, red, busy_ok, pulse_ok);
    model_resolve(WIDTH'(100), er, ered);
    checks++; if (r !== WIDTH'(12)) begin errors++; $display("[TB] FAIL basic_res: got %0d expected 12", r); end
    checks++; if (red !== 1'b0) begin errors++; $display("[TB] FAIL basic_reduced: got %0b expected 0", red); end
    checks++; if (lat !== EXP_LAT) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected %0d", lat, EXP_LAT); end
    checks++; if (!busy_ok) begin errors++; $display("[TB] FAIL basic_busy: cmd_ready got 1 expected 0 while resolving"); end
    checks++; if (!pulse_ok) begin errors++; $display("[TB] FAIL basic_pulse: res_valid/cmd_ready got %0b/%0b expected 0/1", res_valid, cmd_ready); end
    do_op(OP_ACC, WIDTH'(3));
    checks++; if (lsb !== er[0] ^ 1'b1) begin errors++; $display("[TB] FAIL basic_continue_lsb: got %0b expected %0b", lsb, er[0] ^ 1'b1); end
  endtask

  task automatic test_reduce();
    int lat; logic [WIDTH-1:0] r, er; logic red, ered, busy_ok, pulse_ok;
    do_op(OP_CLEAR, '0);
    do_op(OP_ACC, WIDTH'(150));
    do_resolve(WIDTH'(100), lat, r, red, busy_ok, pulse_ok);
    model_resolve(WIDTH'(100), er, ered);
    checks++; if (r !== er) begin errors++; $display("[TB] FAIL reduce_res: got %0d expected %0d", r, er); end
    checks++; if (red !== ered) begin errors++; $display("[TB] FAIL reduce_flag: got %0b expected %0b", red, ered); end
    checks++; if (lat !== EXP_LAT) begin errors++; $display("[TB] FAIL reduce_latency: got %0d expected %0d", lat, EXP_LAT); end
    do_op(OP_CLEAR, '0);
    do_op(OP_ACC, WIDTH'(150));
    do_resolve(WIDTH'(150), lat, r, red, busy_ok, pulse_ok);
    model_resolve(WIDTH'(150), er, ered);
    checks++; if (r !== er) begin errors++; $display("[TB] FAIL equal_res: got %0d expected %0d", r, er); end
    checks++; if (red !== ered) begin errors++; $display("[TB] FAIL equal_flag: got %0b expected %0b", red, ered); end
  endtask

  task automatic test_seg_carry();
    int lat; logic [WIDTH-1:0] r, er, x; logic red, ered, busy_ok, pulse_ok;
    x = (WIDTH'(1) << 103) - WIDTH'(1);
    do_op(OP_CLEAR, '0);
    do_op(OP_ACC, x);
    do_op(OP_ACC, WIDTH'(1));
    do_resolve(all_ones, lat, r, red, busy_ok, pulse_ok);
    model_resolve(all_ones, er, ered);
    checks++; if (r !== (WIDTH'(1) << 103)) begin errors++; $display("[TB] FAIL seg_carry_res: got %0h expected %0h", r, WIDTH'(1) << 103); end
    checks++; if (red !== 1'b0) begin errors++; $display("[TB] FAIL seg_carry_reduced: got %0b expected 0", red); end
    do_op(OP_ACC, WIDTH'(5));
    do_resolve(all_ones, lat, r, red, busy_ok, pulse_ok);
    model_resolve(all_ones, er, ered);
    checks++; if (r !== er) begin errors++; $display("[TB] FAIL seg_continue_res: got %0h expected %0h", r, er); end
  endtask

  task automatic test_lsb_shift();
    int lat; logic [WIDTH-1:0] r, er; logic red, ered, busy_ok, pulse_ok;
    do_op(OP_CLEAR, '0);
    do_op(OP_ACC, WIDTH'(3));
    checks++; if (lsb !== 1'b1) begin errors++; $display("[TB] FAIL acc3_lsb: got %0b expected 1", lsb); end
    do_op(OP_SHIFT, WIDTH'(5));
    checks++; if (lsb !== 1'b0) begin errors++; $display("[TB] FAIL shift_lsb: got %0b expected 0", lsb); end
    do_resolve(WIDTH'(100), lat, r, red, busy_ok, pulse_ok);
    model_resolve(WIDTH'(100), er, ered);
    checks++; if (r !== WIDTH'(4)) begin errors++; $display("[TB] FAIL shift_res: got %0d expected 4", r); end
    do_op(OP_CLEAR, '0);
    do_op(OP_ACC, all_ones);
    do_op(OP_ACC, WIDTH'(2));
    do_resolve(all_ones, lat, r, red, busy_ok, pulse_ok);
    model_resolve(all_ones, er, ered);
    checks++; if (r !== WIDTH'(1)) begin errors++; $display("[TB] FAIL wrap_res: got %0h expected 1", r); end
    checks++; if (red !== 1'b0) begin errors++; $display("[TB] FAIL wrap_reduced: got %0b expected 0", red); end
  endtask

  // ACC 9 is held on the bus throughout a resolve and must land exactly once.
  task automatic test_busy_hold();
    int lat; logic [WIDTH-1:0] r, er; logic red, ered, busy_ok, pulse_ok;
    logic seen, accepted, ready_before;
    logic [WIDTH-1:0] seen_res;
    do_op(OP_CLEAR, '0);
    do_op(OP_ACC, WIDTH'(1));
    wait_ready();
    cmd_valid = 1'b1; cmd_op = OP_RESOLVE; in_m = WIDTH'(100);
    @(posedge clk);
    @(negedge clk);
    cmd_op = OP_ACC; in_a = WIDTH'(9);
    seen = 1'b0; accepted = 1'b0; seen_res = '0;
    for (int n = 0; n < 40 && !accepted; n++) begin
      ready_before = cmd_ready;
      @(posedge clk);
      #1;
      if (res_valid) begin seen = 1'b1; seen_res = res; end
      if (ready_before) accepted = 1'b1;
      else @(negedge clk);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    model_resolve(WIDTH'(100), er, ered);
    checks++; if (!(seen && seen_res === er)) begin errors++; $display("[TB] FAIL busy_first_res: seen=%0b got %0d expected %0d", seen, seen_res, er); end
    checks++; if (!accepted) begin errors++; $display("[TB] FAIL busy_accept: got 0 expected 1"); end
    model_v = model_v + WIDTH'(9);
    do_resolve(WIDTH'(100), lat, r, red, busy_ok, pulse_ok);
    model_resolve(WIDTH'(100), er, ered);
    checks++; if (r !== er) begin errors++; $display("[TB] FAIL busy_once_res: got %0d expected %0d", r, er); end
  endtask

  task automatic test_reset_mid();
    logic seen;
    int lat; logic [WIDTH-1:0] r, er; logic red, ered, busy_ok, pulse_ok;
    do_op(OP_CLEAR, '0);
    do_op(OP_ACC, WIDTH'(77));
    wait_ready();
    cmd_valid = 1'b1; cmd_op = OP_RESOLVE; in_m = WIDTH'(50);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    model_v = '0;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL midreset_ready: got %0b expected 1", cmd_ready); end
    checks++; if (res !== '0) begin errors++; $display("[TB] FAIL midreset_res: got %0h expected 0", res); end
    @(negedge clk);
    resetn = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (res_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("[TB] FAIL midreset_novalid: got %0b expected 0", seen); end
    do_op(OP_ACC, WIDTH'(3));
    do_resolve(WIDTH'(100), lat, r, red, busy_ok, pulse_ok);
    model_resolve(WIDTH'(100), er, ered);
    checks++; if (r !== WIDTH'(3)) begin errors++; $display("[TB] FAIL midreset_after_res: got %0d expected 3", r); end
  endtask

  // Consecutive random ops land on consecutive edges; parity and resolve follow the model.
  task automatic test_back_to_back_random();
    int lat; logic [WIDTH-1:0] r, er, a, m; logic red, ered, busy_ok, pulse_ok;
    logic [1:0] op;
    for (int round = 0; round < 8; round++) begin
      do_op(OP_CLEAR, '0);
      for (int k = 0; k < int'($urandom_range(2, 6)); k++) begin
        op = ($urandom_range(0, 2) == 0) ? OP_SHIFT : OP_ACC;
        a = rand_wide(int'($urandom_range(1, 508)));
        do_op(op, a);
        checks++; if (lsb !== model_v[0]) begin errors++; $display("[TB] FAIL rand_lsb r%0d k%0d: got %0b expected %0b", round, k, lsb, model_v[0]); end
      end
      case ($urandom_range(0, 2))
        0: m = model_v;
        1: m = model_v + WIDTH'(1);
        default: m = rand_wide(int'($urandom_range(1, 510)));
      endcase
      do_resolve(m, lat, r, red, busy_ok, pulse_ok);
      model_resolve(m, er, ered);
      checks++; if (r !== er) begin errors++; $display("[TB] FAIL rand_res r%0d: got %0h expected %0h", round, r, er); end
      checks++; if (red !== ered) begin errors++; $display("[TB] FAIL rand_reduced r%0d: got %0b expected %0b", round, red, ered); end
      checks++; if (lat !== EXP_LAT) begin errors++; $display("[TB] FAIL rand_latency r%0d: got %0d expected %0d", round, lat, EXP_LAT); end
    end
  endtask

  initial begin
    all_ones = '1;
    test_reset();
    test_basic();
    test_reduce();
    test_seg_carry();
    test_lsb_shift();
    test_busy_hold();
    test_reset_mid();
    test_back_to_back_random();
    @(negedge clk);
    cmd_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mp_csa_accum.md
# mp_csa_accum

Parametrised carry-save accumulator for the Montgomery datapath: accumulates WIDTH-bit operands in redundant (sum/carry) form at one operand per cycle, with optional divide-by-two per step, and on request resolves the redundant value to binary through a SEG-bit segmented carry-propagate adder. An optional final conditional subtraction of the modulus is included. It sits between the Montgomery controller, which issues commands and reads `lsb` for quotient-bit selection, and the result/output path.

## Interface
- `WIDTH`, 514: operand and accumulator width.
- `SEG`, 103: carry-propagate segment width; `NSEG = ceil(WIDTH/SEG)` (localparam, 5 by default); last segment `WIDTH-(NSEG-1)*SEG` bits.
- `clk`  in  1  clock; all state on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  high in IDLE only; command accepted on edge with `cmd_valid & cmd_ready`.
- `cmd_op`  in  2  00 CLEAR, 01 ACC, 10 ACC_SHIFT, 11 RESOLVE.
- `in_a`  in  WIDTH  addend; sampled on accept edge only.
- `in_m`  in  WIDTH  modulus; held stable by master from RESOLVE accept until `res_valid`.
- `lsb`  out  1  `S[0]^C[0]`, current accumulator parity.
- `res`  out  WIDTH  registered S; valid when `res_valid`, held until next accepted command.
- `res_valid`  out  1  one-cycle pulse at RESOLVE completion.
- `res_reduced`  out  1  1 if the modulus was subtracted; valid with `res_valid`.

## Operation
- State: S, C (WIDTH each); value V = S + C mod 2^WIDTH; C[0] always 0.
- CLEAR: S=C=0, single cycle.
- ACC: S ← S^C^A; C ← {maj(S,C,A)[WIDTH-2:0],0}; bits beyond WIDTH dropped. Single cycle.
- ACC_SHIFT: same as ACC, then S and C each shifted right 1, MSB 0; yields floor((V+A)/2). Single cycle.
- RESOLVE FSM: IDLE → PROP → SUB → DONE → IDLE.
  - PROP: segment k = 0..NSEG-1, one per cycle: `{cy,R_k} = S_k + C_k + cy`; R_k written into S_k, C_k cleared; `cy` register cleared on entry; final carry dropped.
  - SUB: segment k per cycle: `{bw,D_k} = S_k - M_k - bw`; D_k written into C_k (scratch). After last segment: if final borrow 0 (S ≥ M), S ← D and `res_reduced`=1, else S kept and `res_reduced`=0; C cleared in both cases.
  - DONE: `res_valid`=1 for one cycle.
- After RESOLVE, S holds binary result, C=0; further ACC commands continue from it.
- `cmd_valid` while not IDLE: ignored; master holds request until `cmd_ready`.
- Segment counter runs 0..NSEG-1, then resets to 0 on each phase change.

## Timing
- Reset (async assert, sync-deasserted externally): S=C=0, FSM IDLE, `cmd_ready`=1, `res_valid`=0, `res`=0, `res_reduced`=0, `lsb`=0.
- CLEAR/ACC/ACC_SHIFT: result visible the cycle after accept edge; `cmd_ready` stays 1, back-to-back every cycle.
- RESOLVE accepted at edge E0: PROP on E1..E_NSEG, SUB on E_NSEG+1..E_2NSEG, DONE entered at E_2NSEG+1; `res_valid` high the following cycle. `cmd_ready` low from E0 until DONE exits to IDLE. Default latency: 11 edges to DONE.
- Reset during PROP/SUB: immediate abort; no `res_valid`; all state at reset values.

## Configuration
- `MP_CSA_COND_SUB_EN` defined: SUB phase present as above.
- Not defined: PROP → DONE directly (DONE entered at E_NSEG+1); `res` = V mod 2^WIDTH; `res_reduced` tied 0; `in_m` unused.

## Test plan
- Reset; ACC 5, ACC 7, RESOLVE M=100 → `res`=12, `res_reduced`=0, `res_valid` one cycle, DONE 11 edges after accept.
- ACC 150, RESOLVE M=100 → `res`=50, reduced=1; CLEAR, ACC 150, RESOLVE M=150 → `res`=0, reduced=1 (equality boundary).
- ACC 2^103−1, ACC 1, RESOLVE M=2^WIDTH−1 → `res`=2^103 (carry crosses segment 0→1), reduced=0.
- ACC 3 → `lsb`=1; ACC_SHIFT 5 → `lsb`=0; RESOLVE M=100 → `res`=4; wrap: CLEAR, ACC 2^WIDTH−1, ACC 2, RESOLVE M=2^WIDTH−1 → `res`=1.
- `cmd_valid` with ACC 9 held during RESOLVE busy → ignored until `cmd_ready`, then applied exactly once.
- `resetn` low mid-PROP → no `res_valid`, `cmd_ready`=1, `res`=0; with macro undefined, ACC 150 RESOLVE M=100 → `res`=150, DONE 6 edges after accept.
